// File: rtl/ifetch_pkg.sv
// Shared fetch-queue types and constants.
// INSTR_W/PC_STEP constants, fetch_entry_t, saturating add helper.
package ifetch_pkg;

    localparam int INSTR_W  = 32;
    localparam int PC_STEP  = 4;
    localparam int PC_MAX_W = 64;

    typedef struct packed {
        logic [INSTR_W-1:0]  instr;
        logic [PC_MAX_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction queue: power-of-two ring buffer with flush.
// Ports: push/push_data, pop/head, flush, full, empty, count.
module ifetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    assign empty = (r_cnt == '0);
    assign full  = (r_cnt == (AW+1)'(DEPTH));
    assign count = r_cnt;
    assign head  = r_mem[r_rd];

    // A full queue may accept a push when the head leaves the same cycle.
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= push_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch unit: issues word fetches, queues returned instructions, handles redirects.
// Ports: clock/reset, imem_req_*, imem_rsp_*, redirect_*, out_*; perf_* with IFETCH_PERF_CNT_EN.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_pc_plus4
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed,
    output logic [31:0]        perf_stall
`endif
);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int EW = INSTR_W + XLEN;
    localparam logic [XLEN-1:0] RESET_PC_A = {RESET_PC[XLEN-1:2], 2'b00};

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outst;
    logic [CW-1:0]   r_discard;

    logic            w_fire;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [CW:0]     w_sum;
    logic [CW-1:0]   w_outst_nxt;
    logic [XLEN-1:0] w_tgt;
    logic [EW-1:0]   w_fifo_q;
    fetch_entry_t    w_head;
    logic            w_unused_pc;

    assign w_tgt  = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_fire = imem_req_valid && imem_req_ready;
    assign w_drop = imem_rsp_valid && (r_discard != '0);
    assign w_push = imem_rsp_valid && !w_drop && !redirect_valid;
    assign w_pop  = out_valid && out_ready && !redirect_valid;

    // Queued plus in-flight never exceeds the queue depth.
    assign w_sum          = {1'b0, w_count} + {1'b0, r_outst};
    assign imem_req_valid = reset && (w_sum < (CW+1)'(QDEPTH));
    assign imem_req_addr  = r_fetch_pc;

    assign w_outst_nxt = r_outst + CW'(w_fire) - CW'(imem_rsp_valid);

    ifetch_fifo #(
        .WIDTH (EW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data ({imem_rsp_data, r_rsp_pc}),
        .pop       (w_pop),
        .head      (w_fifo_q),
        .flush     (redirect_valid),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign w_head = '{
        instr: w_fifo_q[EW-1:XLEN],
        pc:    PC_MAX_W'(w_fifo_q[XLEN-1:0])
    };
    assign w_unused_pc = ^(w_head.pc >> XLEN);

    // Outputs read zero whenever the head is not valid.
    assign out_valid    = !w_empty;
    assign out_instr    = out_valid ? w_head.instr : '0;
    assign out_pc       = out_valid ? w_head.pc[XLEN-1:0] : '0;
    assign out_pc_plus4 = out_valid ?
                          w_head.pc[XLEN-1:0] + XLEN'(PC_STEP) : '0;

    // r_rsp_pc tracks the address of the next response that will be kept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC_A;
            r_rsp_pc   <= RESET_PC_A;
            r_outst    <= '0;
            r_discard  <= '0;
        end else begin
            r_outst <= w_outst_nxt;
            if (redirect_valid) begin
                r_fetch_pc <= w_tgt;
                r_rsp_pc   <= w_tgt;
                r_discard  <= w_outst_nxt;
            end else begin
                if (w_fire) r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
                if (w_push) r_rsp_pc   <= r_rsp_pc + XLEN'(PC_STEP);
                if (w_drop) r_discard  <= r_discard - CW'(1);
            end
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_flushed;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_push)
                r_perf_fetched <= sat_add(r_perf_fetched, 32'd1);
            if (redirect_valid)
                r_perf_flushed <= sat_add(r_perf_flushed,
                                  32'(w_count) + 32'(imem_rsp_valid));
            else if (w_drop)
                r_perf_flushed <= sat_add(r_perf_flushed, 32'd1);
            if (out_ready && !out_valid)
                r_perf_stall <= sat_add(r_perf_stall, 32'd1);
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushed = r_perf_flushed;
    assign perf_stall   = r_perf_stall;
`endif

    a_rsp_outst: assert property (
        @(posedge clock) disable iff (!reset)
        imem_rsp_valid |-> (r_outst != '0));

    a_no_ovf: assert property (
        @(posedge clock) disable iff (!reset)
        w_push |-> (!w_full || w_pop));

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: in-order memory model,
// expected-PC stream scoreboard, directed and random phases.
module tb_ifetch_queue;

    localparam int          XLEN   = 32;
    localparam int          QDEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clock          = 1'b0;
    logic        reset          = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        out_valid;
    logic        out_ready      = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
    logic [31:0] perf_stall;
`endif

    ifetch_queue #(
        .XLEN     (XLEN),
        .QDEPTH   (QDEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] tgt_q[$];
    int          total   = 0;
    int          bad     = 0;
    int          cyc     = 0;
    int          n_fire  = 0;
    int          n_pop   = 0;
    int          n_pop_r = 0;
    int          n_stall = 0;
    logic [31:0] exp_pc  = RST_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs; memory answers in order after lat cycles.
    task automatic drive(input bit rst, input bit rq, input bit ordy,
                         input bit rd, input logic [31:0] tgt,
                         input int lat);
        cyc++;
        if (rst && !reset) begin
            mq.delete();
            tgt_q.delete();
        end
        reset          = rst;
        imem_req_ready = rq;
        out_ready      = ordy;
        redirect_valid = rd;
        redirect_pc    = tgt;
        if (rd) tgt_q.push_back(tgt);
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        if (imem_req_valid && rq) begin
            mq.push_back('{imem_req_addr, cyc + lat});
            n_fire++;
            chk("cap", 32'(mq.size() <= QDEPTH), 32'd1);
        end
    endtask

    task automatic step(input bit rst, input bit rq, input bit ordy,
                        input bit rd, input logic [31:0] tgt,
                        input int lat);
        @(negedge clock);
        drive(rst, rq, ordy, rd, tgt, lat);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1);
    endtask

`ifdef IFETCH_PERF_CNT_EN
    task automatic perf_chk(input logic [31:0] e_flush);
        @(negedge clock);
        chk("perf_fetched", perf_fetched, 32'(n_pop_r));
        chk("perf_flushed", perf_flushed, e_flush);
        chk("perf_stall", perf_stall, 32'(n_stall));
        drive(1'b1, 1'b0, 1'b1, 1'b0, '0, 1);
    endtask
`endif

    // Monitor: every consumed head must follow the architectural PC stream.
    initial begin
        forever begin
            @(negedge clock);
            #1;
            if (!reset) begin
                exp_pc  = RST_PC;
                n_stall = 0;
                n_pop_r = 0;
            end else begin
                if (out_ready && !out_valid) n_stall++;
                if (out_valid && out_ready) begin
                    chk("out_pc", out_pc, exp_pc);
                    chk("out_instr", out_instr, mem_word(exp_pc));
                    chk("out_pc_plus4", out_pc_plus4, exp_pc + 32'd4);
                    exp_pc = exp_pc + 32'd4;
                    n_pop++;
                    n_pop_r++;
                end
                if (redirect_valid && tgt_q.size() > 0)
                    exp_pc = tgt_q.pop_front() & 32'hFFFF_FFFC;
            end
        end
    end

    initial begin
        int f0;
        int p0;
        bit rd;

        // Reset values, then first fetch and its latency.
        do_reset(3);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_pc_plus4", out_pc_plus4, 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1);
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, RST_PC);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1);
        chk("lat_rsp_cycle", 32'(out_valid), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1);
        chk("lat_rsp_plus1", 32'(out_valid), 32'd1);
        chk("first_head_pc", out_pc, RST_PC);
        chk("first_head_plus4", out_pc_plus4, RST_PC + 32'd4);
        repeat (10) step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1);

        // Backpressure: four requests fill the queue, then fetch stops.
        do_reset(3);
        f0 = n_fire;
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1);
        chk("bp_instr_mid", out_instr, mem_word(RST_PC));
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1);
        chk("bp_fires", 32'(n_fire - f0), 32'd4);
        chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_instr_end", out_instr, mem_word(RST_PC));
        repeat (12) step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1);

        // Redirect with two requests in flight at 3-cycle latency.
        do_reset(2);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, 3);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, 3);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0103, 3);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1);
        chk("rd_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rd_req_addr", imem_req_addr, 32'h0000_0100);
        p0 = n_pop;
        repeat (12) step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1);
        repeat (8) step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1);
        chk("rd_progress", 32'(n_pop - p0 >= 5), 32'd1);
        chk("rd_drained", 32'(out_valid), 32'd0);
`ifdef IFETCH_PERF_CNT_EN
        perf_chk(32'd2);
`endif

        // Address wrap through the top of the address space.
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1);
        p0 = n_pop;
        repeat (12) step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1);
        chk("wrap_progress", 32'(n_pop - p0 >= 5), 32'd1);

        // Reset asserted with two requests outstanding.
        do_reset(2);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, 3);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, 3);
        do_reset(4);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1);
        chk("mid_rst_req_addr", imem_req_addr, RST_PC);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
`ifdef IFETCH_PERF_CNT_EN
        chk("mid_rst_perf_fetched", perf_fetched, 32'd0);
        chk("mid_rst_perf_flushed", perf_flushed, 32'd0);
        chk("mid_rst_perf_stall", perf_stall, 32'd0);
`endif
        p0 = n_pop;
        repeat (10) step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1);
        chk("mid_rst_progress", 32'(n_pop - p0 >= 4), 32'd1);

        // Random traffic, latency and redirects.
        p0 = n_pop;
        repeat (3000) begin
            rd = ($urandom_range(0, 39) == 0);
            step(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 rd, $urandom, $urandom_range(1, 4));
        end
        repeat (24) step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1);
        chk("rand_progress", 32'(n_pop - p0 >= 300), 32'd1);
        chk("rand_drained", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
